rom_fetch_ctrl: RTL and testbench

// - Instruction-fetch sequencer for the 14-bit MCU core. It drives Program_Rom's 11-bit address
//   and latches the returned word into the instruction register (IR) for the execute stage.
// - Owns the PC and the hardware call stack. Decodes GOTO/CALL/RETURN/RETLW and the execute-stage skip.
// - Two-stage overlap: fetch addr N+1 while executing IR(N). Redirects insert exactly one bubble.

---
 rtl/mcu_pkg.sv | 35 +++
 rtl/call_stack.sv | 69 ++++++
 rtl/rom_fetch_ctrl.sv | 80 ++++++++
 tb/tb_rom_fetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared widths, opcode encodings and decode helpers for the 14-bit MCU fetch path.
package mcu_pkg;

    localparam int PC_W    = 11;
    localparam int INSTR_W = 14;

    localparam logic [INSTR_W-1:0] OP_JMP_MASK   = 14'h3800;
    localparam logic [INSTR_W-1:0] OP_GOTO       = 14'h2800;
    localparam logic [INSTR_W-1:0] OP_CALL       = 14'h2000;
    localparam logic [INSTR_W-1:0] OP_RETURN     = 14'h0008;
    localparam logic [INSTR_W-1:0] OP_RETLW_MASK = 14'h3C00;
    localparam logic [INSTR_W-1:0] OP_RETLW      = 14'h3400;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } fetch_state_t;

    function automatic logic is_goto(input logic [INSTR_W-1:0] w);
        return (w & OP_JMP_MASK) == OP_GOTO;
    endfunction

    function automatic logic is_call(input logic [INSTR_W-1:0] w);
        return (w & OP_JMP_MASK) == OP_CALL;
    endfunction

    function automatic logic is_ret(input logic [INSTR_W-1:0] w);
        return (w == OP_RETURN) || ((w & OP_RETLW_MASK) == OP_RETLW);
    endfunction

    function automatic logic [PC_W-1:0] jump_target(input logic [INSTR_W-1:0] w);
        return w[PC_W-1:0];
    endfunction

endpackage

// File: rtl/call_stack.sv
// Circular hardware call stack; optional live-depth tracking and sticky error flags
// are built only when STACK_ERR_EN is defined.
module call_stack
    import mcu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] pop_data,
    output logic            ovf,
    output logic            unf
);

    localparam int unsigned SP_W = $clog2(DEPTH);

    logic [SP_W-1:0] sp;
    logic [PC_W-1:0] mem [DEPTH];

    // Pointer wraps naturally at power-of-two depth: overflow overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
        end
    end

    assign pop_data = mem[sp - 1'b1];

`ifdef STACK_ERR_EN
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] depth;

    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            if (depth == CNT_W'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                depth <= depth + 1'b1;
            end
        end else if (pop) begin
            if (depth == '0) begin
                unf <= 1'b1;
            end else begin
                depth <= depth - 1'b1;
            end
        end
    end
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, IR and redirect handling over a two-stage overlap.
// Stack error flags are live only when STACK_ERR_EN is defined.
module rom_fetch_ctrl
    import mcu_pkg::*;
#(
    parameter int unsigned     STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               stall,
    input  logic               skip_req,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic               stack_ovf,
    output logic               stack_unf
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pop_data;
    logic            exec;
    logic            push;
    logic            pop;

    // Stack traffic only for a valid, unstalled instruction in RUN; bubbles never touch it.
    always_comb begin
        exec = (state == ST_RUN) && ir_valid && !stall;
        push = exec && is_call(ir);
        pop  = exec && is_ret(ir);
    end

    call_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_data(pc),
        .pop_data (pop_data),
        .ovf      (stack_ovf),
        .unf      (stack_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else if (!stall) begin
            state <= ST_RUN;
            ir    <= rom_data;
            case (state)
                ST_BOOT: begin
                    ir_valid <= 1'b1;
                    pc       <= pc + 1'b1;
                end
                default: begin
                    if (ir_valid && (is_goto(ir) || is_call(ir))) begin
                        pc       <= jump_target(ir);
                        ir_valid <= 1'b0;
                    end else if (ir_valid && is_ret(ir)) begin
                        pc       <= pop_data;
                        ir_valid <= 1'b0;
                    end else begin
                        pc       <= pc + 1'b1;
                        ir_valid <= ~skip_req;
                    end
                end
            endcase
        end
    end

    assign rom_addr = pc;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: directed program scenarios plus randomized
// stall/skip traffic against an instruction-level reference model.
module tb_rom_fetch_ctrl;

    localparam int DEPTH = 8;
    localparam int NPC   = 2048;

    logic        clk;
    logic        rst;
    logic [10:0] rom_addr;
    logic [13:0] rom_data;
    logic        stall;
    logic        skip_req;
    logic [13:0] ir;
    logic        ir_valid;
    logic        stack_ovf;
    logic        stack_unf;

    logic [13:0] rom [NPC];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_pc;
    logic [13:0] m_ir;
    logic        m_v;
    logic        m_boot;
    int          m_stk [DEPTH];
    int          m_sp;
    int          m_depth;
    logic        m_ovf;
    logic        m_unf;

    rom_fetch_ctrl #(
        .STACK_DEPTH(DEPTH),
        .RESET_PC   (11'h000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .stall    (stall),
        .skip_req (skip_req),
        .ir       (ir),
        .ir_valid (ir_valid),
        .stack_ovf(stack_ovf),
        .stack_unf(stack_unf)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_rom();
        for (int i = 0; i < NPC; i++) rom[i] = 14'h0000;
    endtask

    // Instruction-level behaviour: what the next fetch address and IR status must be.
    task automatic model_update();
        logic [13:0] w;
        if (rst) begin
            m_pc = 0; m_ir = '0; m_v = 1'b0; m_boot = 1'b1;
            m_sp = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
        end else if (!stall) begin
            w = rom[m_pc];
            if (m_boot) begin
                m_boot = 1'b0; m_v = 1'b1; m_pc = (m_pc + 1) % NPC;
            end else if (m_v && m_ir[13:11] == 3'b101) begin
                m_pc = int'(m_ir[10:0]); m_v = 1'b0;
            end else if (m_v && m_ir[13:11] == 3'b100) begin
                m_stk[m_sp] = m_pc;
                m_sp = (m_sp + 1) % DEPTH;
                if (m_depth == DEPTH) m_ovf = 1'b1; else m_depth++;
                m_pc = int'(m_ir[10:0]); m_v = 1'b0;
            end else if (m_v && (m_ir == 14'h0008 || m_ir[13:10] == 4'b1101)) begin
                m_sp = (m_sp + DEPTH - 1) % DEPTH;
                if (m_depth == 0) m_unf = 1'b1; else m_depth--;
                m_pc = m_stk[m_sp]; m_v = 1'b0;
            end else begin
                m_v = !skip_req; m_pc = (m_pc + 1) % NPC;
            end
            m_ir = w;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic load_linear_program();
        clear_rom();
        rom[0]  = 14'h3018; rom[1]  = 14'h00A3; rom[2]  = 14'h01A1;
        rom[3]  = 14'h2805; rom[4]  = 14'h0155; rom[5]  = 14'h2020;
        rom[6]  = 14'h0123; rom[7]  = 14'h0456; rom[8]  = 14'h0789;
        rom[9]  = 14'h0ABC; rom[10] = 14'h0DEF; rom[11] = 14'h2810;
        rom[12] = 14'h0333; rom[16] = 14'h0111; rom[17] = 14'h0222;
        rom[32] = 14'h3400;
    endtask

    task automatic test_reset();
        load_linear_program();
        rst = 1'b1; stall = 1'b1; skip_req = 1'b0;
        step(); step();
        checks++;
        if (rom_addr !== 11'h000 || ir !== 14'h0000 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: got addr=%h ir=%h v=%b, need addr=000 ir=0000 v=0", rom_addr, ir, ir_valid);
        end
        checks++;
        if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ovf=%b unf=%b, need 0 0", stack_ovf, stack_unf);
        end
        rst = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if (ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_cycle: got ir_valid=%b need 0", ir_valid);
        end
    endtask

    // Linear fetch, GOTO, CALL/RETLW and skip handling along one program.
    task automatic test_program_flow();
        int          e_addr [17] = '{1, 2, 3, 4, 5, 6, 32, 33, 6, 7, 8, 9, 10, 11, 12, 16, 17};
        logic        e_v    [17] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1};
        logic [13:0] e_ir   [17] = '{14'h3018, 14'h00A3, 14'h01A1, 14'h2805, 14'h0, 14'h2020,
                                     14'h0, 14'h3400, 14'h0, 14'h0123, 14'h0456, 14'h0789,
                                     14'h0, 14'h0DEF, 14'h2810, 14'h0, 14'h0111};
        logic        s_in   [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        for (int k = 0; k < 17; k++) begin
            skip_req = s_in[k];
            step();
            skip_req = 1'b0;
            checks++;
            if (rom_addr !== 11'(e_addr[k]) || ir_valid !== e_v[k] || (e_v[k] && ir !== e_ir[k])) begin
                errors++;
                $display("FAIL flow_edge%0d: got addr=%h v=%b ir=%h, need addr=%h v=%b ir=%h",
                         k + 1, rom_addr, ir_valid, ir, 11'(e_addr[k]), e_v[k], e_ir[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [10:0] a0;
        logic [13:0] i0;
        logic        v0;
        a0 = 11'h011; i0 = 14'h0111; v0 = 1'b1;
        stall = 1'b1;
        skip_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (rom_addr !== a0 || ir !== i0 || ir_valid !== v0) begin
                errors++;
                $display("FAIL stall_hold%0d: got addr=%h ir=%h v=%b, need addr=%h ir=%h v=%b",
                         k, rom_addr, ir, ir_valid, a0, i0, v0);
            end
        end
        stall = 1'b0;
        step();
        skip_req = 1'b0;
        checks++;
        if (rom_addr !== 11'h012 || ir !== 14'h0222 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release_skip: got addr=%h ir=%h v=%b, need addr=012 ir=0222 v=0",
                     rom_addr, ir, ir_valid);
        end
    endtask

    // 9 nested calls then returns: oldest entry overwritten, final return wraps.
    task automatic test_stack_wrap();
        logic ex_ovf, ex_unf;
        clear_rom();
        for (int k = 0; k < 9; k++) begin
            rom[2*k]     = 14'h2000 | 14'(2*k + 2);
            rom[2*k + 1] = 14'h0008;
        end
        rom[18] = 14'h0008;
        rst = 1'b1; stall = 1'b0; skip_req = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 70; c++) begin
            step();
            checks++;
            if (rom_addr !== 11'(m_pc) || ir_valid !== m_v || (m_v && ir !== m_ir)) begin
                errors++;
                $display("FAIL stack_cyc%0d: got addr=%h v=%b ir=%h, need addr=%h v=%b ir=%h",
                         c, rom_addr, ir_valid, ir, 11'(m_pc), m_v, m_ir);
            end
        end
`ifdef STACK_ERR_EN
        ex_ovf = 1'b1; ex_unf = 1'b1;
`else
        ex_ovf = 1'b0; ex_unf = 1'b0;
`endif
        checks++;
        if (stack_ovf !== ex_ovf || stack_unf !== ex_unf) begin
            errors++;
            $display("FAIL stack_flags: got ovf=%b unf=%b, need ovf=%b unf=%b",
                     stack_ovf, stack_unf, ex_ovf, ex_unf);
        end
    endtask

    task automatic test_random();
        int          r;
        logic [13:0] w;
        logic        ex_ovf, ex_unf;
        for (int a = 0; a < NPC; a++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6)       w = 14'h2800 | 14'($urandom_range(0, NPC - 1));
            else if (r < 12) w = 14'h2000 | 14'($urandom_range(0, NPC - 1));
            else if (r < 15) w = 14'h0008;
            else if (r < 18) w = 14'h3400 | 14'($urandom_range(0, 1023));
            else begin
                w = 14'($urandom_range(0, 4095));
                if (w == 14'h0008) w = 14'h0009;
            end
            rom[a] = w;
        end
        rst = 1'b1; stall = 1'b0; skip_req = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            skip_req = ($urandom_range(0, 4) == 0);
            step();
`ifdef STACK_ERR_EN
            ex_ovf = m_ovf; ex_unf = m_unf;
`else
            ex_ovf = 1'b0; ex_unf = 1'b0;
`endif
            checks++;
            if (rom_addr !== 11'(m_pc) || ir_valid !== m_v || (m_v && ir !== m_ir) ||
                stack_ovf !== ex_ovf || stack_unf !== ex_unf) begin
                errors++;
                $display("FAIL rand_cyc%0d: got addr=%h v=%b ir=%h ovf=%b unf=%b, need addr=%h v=%b ir=%h ovf=%b unf=%b",
                         c, rom_addr, ir_valid, ir, stack_ovf, stack_unf,
                         11'(m_pc), m_v, m_ir, ex_ovf, ex_unf);
            end
        end
        rst = 1'b0; stall = 1'b0; skip_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b1; skip_req = 1'b0;
        test_reset();
        test_program_flow();
        test_stall();
        test_stack_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
